// File: rtl/trim_seq_if.sv
// Request/result bundle for trim_seq: the requester drives strobe, the
// per-channel magnitudes and gains and the overrun clear; the trimmer
// returns the packed results, the completion toggle and status flags.
interface trim_seq_if #(
    parameter int NCHAN      = 4,
    parameter int MAG_WIDTH  = 26,
    parameter int GAIN_WIDTH = 27
);
    logic                         strobe;
    logic [NCHAN*MAG_WIDTH-1:0]   magnitudes;
    logic [NCHAN*GAIN_WIDTH-1:0]  gains;
    logic                         overrunClear;
    logic [NCHAN*MAG_WIDTH-1:0]   trimmed;
    logic                         trimmedToggle;
    logic [NCHAN-1:0]             saturated;
    logic                         busy;
    logic                         overrun;

    modport master (
        output strobe, magnitudes, gains, overrunClear,
        input  trimmed, trimmedToggle, saturated, busy, overrun
    );

    modport slave (
        input  strobe, magnitudes, gains, overrunClear,
        output trimmed, trimmedToggle, saturated, busy, overrun
    );
endinterface

// File: rtl/trim_seq.sv
// Multi-channel gain trimmer. A strobe snapshots all channel magnitudes and
// gains, then one shared pipelined multiplier processes the channels in
// ascending order. Rounded, saturated products are gathered in a hidden
// buffer and published to the outputs all at once, with a toggle marking
// each completed result set.
module trim_seq #(
    parameter int NCHAN        = 4,
    parameter int MAG_WIDTH    = 26,
    parameter int GAIN_WIDTH   = 27,
    parameter int MULT_LATENCY = 6
) (
    input logic       clk,
    input logic       reset,
    trim_seq_if.slave bus
);
    localparam int PW   = MAG_WIDTH + GAIN_WIDTH;
    localparam int RW   = MAG_WIDTH + 2;
    localparam int IDXW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam logic [IDXW-1:0] LAST_CH = IDXW'(NCHAN - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, UPDATE} state_t;

    state_t state, nextState;
    logic   accept, issueValid, doUpdate;

    logic [IDXW-1:0]       chIdx;
    logic [MAG_WIDTH-1:0]  magSnap  [NCHAN];
    logic [GAIN_WIDTH-1:0] gainSnap [NCHAN];

    logic [PW-1:0]   pipeData  [MULT_LATENCY];
    logic [IDXW-1:0] pipeTag   [MULT_LATENCY];
    logic            pipeValid [MULT_LATENCY];

    logic [PW-1:0]        pOut;
    logic [RW-1:0]        roundedSum;
    logic                 satNow;
    logic [MAG_WIDTH-1:0] resNow;
    logic                 unusedLowBits;

    logic [MAG_WIDTH-1:0] resultBuf [NCHAN];
    logic [NCHAN-1:0]     satBuf;

    logic [NCHAN*MAG_WIDTH-1:0] trimmedReg;
    logic [NCHAN-1:0]           saturatedReg;
    logic                       toggleReg;
    logic                       busyReg;
    logic                       overrunReg;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Next-state decode: accept in IDLE, issue one channel per cycle, wait for
    // the last channel's product to leave the pipeline, then publish
    always_comb begin
        nextState  = state;
        accept     = 1'b0;
        issueValid = 1'b0;
        doUpdate   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.strobe) begin
                    accept    = 1'b1;
                    nextState = ISSUE;
                end
            end
            ISSUE: begin
                issueValid = 1'b1;
                if (chIdx == LAST_CH) nextState = DRAIN;
            end
            DRAIN: begin
                if (pipeValid[MULT_LATENCY-1] && pipeTag[MULT_LATENCY-1] == LAST_CH)
                    nextState = UPDATE;
            end
            UPDATE: begin
                doUpdate  = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Snapshot inputs on acceptance and step the channel index while issuing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chIdx <= '0;
            for (int k = 0; k < NCHAN; k++) begin
                magSnap[k]  <= '0;
                gainSnap[k] <= '0;
            end
        end else if (accept) begin
            chIdx <= '0;
            for (int k = 0; k < NCHAN; k++) begin
                magSnap[k]  <= bus.magnitudes[k*MAG_WIDTH +: MAG_WIDTH];
                gainSnap[k] <= bus.gains[k*GAIN_WIDTH +: GAIN_WIDTH];
            end
        end else if (issueValid) begin
            chIdx <= chIdx + 1'b1;
        end
    end

    // Shared multiplier pipeline; each product carries a valid bit and its channel tag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MULT_LATENCY; i++) begin
                pipeData[i]  <= '0;
                pipeTag[i]   <= '0;
                pipeValid[i] <= 1'b0;
            end
        end else begin
            pipeData[0]  <= PW'(magSnap[chIdx]) * PW'(gainSnap[chIdx]);
            pipeTag[0]   <= chIdx;
            pipeValid[0] <= issueValid;
            for (int i = 1; i < MULT_LATENCY; i++) begin
                pipeData[i]  <= pipeData[i-1];
                pipeTag[i]   <= pipeTag[i-1];
                pipeValid[i] <= pipeValid[i-1];
            end
        end
    end

    // Scale the product back by the unity gain with round-half-up, then clamp
    always_comb begin
        pOut          = pipeData[MULT_LATENCY-1];
        roundedSum    = RW'(pOut[GAIN_WIDTH-1 +: MAG_WIDTH+1]) + RW'(pOut[GAIN_WIDTH-2]);
        satNow        = |roundedSum[RW-1:MAG_WIDTH];
        resNow        = satNow ? {MAG_WIDTH{1'b1}} : roundedSum[MAG_WIDTH-1:0];
        unusedLowBits = ^pOut[GAIN_WIDTH-3:0];
    end

    // Collect finished channels out of sight until the whole set is ready
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            satBuf <= '0;
            for (int k = 0; k < NCHAN; k++) resultBuf[k] <= '0;
        end else if (pipeValid[MULT_LATENCY-1]) begin
            resultBuf[pipeTag[MULT_LATENCY-1]] <= resNow;
            satBuf[pipeTag[MULT_LATENCY-1]]    <= satNow;
        end
    end

    // Publish the complete set in one edge and track busy and sticky overrun
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trimmedReg   <= '0;
            saturatedReg <= '0;
            toggleReg    <= 1'b0;
            busyReg      <= 1'b0;
            overrunReg   <= 1'b0;
        end else begin
            if (doUpdate) begin
                for (int k = 0; k < NCHAN; k++)
                    trimmedReg[k*MAG_WIDTH +: MAG_WIDTH] <= resultBuf[k];
                saturatedReg <= satBuf;
                toggleReg    <= ~toggleReg;
            end
            if (accept)        busyReg <= 1'b1;
            else if (doUpdate) busyReg <= 1'b0;
            overrunReg <= (overrunReg & ~bus.overrunClear) | (bus.strobe & (state != IDLE));
        end
    end

    assign bus.trimmed       = trimmedReg;
    assign bus.saturated     = saturatedReg;
    assign bus.trimmedToggle = toggleReg;
    assign bus.busy          = busyReg;
    assign bus.overrun       = overrunReg;
endmodule

// File: tb/tb_trim_seq.sv
// Directed bench for trim_seq: a default-sized instance for the main
// function, overrun and reset behaviour, plus 1- and 8-channel instances
// with a 3-stage multiplier for latency and packing at other sizes.
module tb_trim_seq;
    localparam longint U   = 67108864;
    localparam longint H   = 33554432;
    localparam longint MX  = 67108863;
    localparam longint GMX = 134217727;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   sel;

    logic         curToggle, curBusy, curOverrun;
    logic [255:0] curTrim;
    logic [15:0]  curSat;

    trim_seq_if #(.NCHAN(4), .MAG_WIDTH(26), .GAIN_WIDTH(27)) busA ();
    trim_seq_if #(.NCHAN(1), .MAG_WIDTH(26), .GAIN_WIDTH(27)) busB ();
    trim_seq_if #(.NCHAN(8), .MAG_WIDTH(26), .GAIN_WIDTH(27)) busC ();

    trim_seq #(.NCHAN(4), .MAG_WIDTH(26), .GAIN_WIDTH(27), .MULT_LATENCY(6))
        dutA (.clk(clk), .reset(reset), .bus(busA.slave));
    trim_seq #(.NCHAN(1), .MAG_WIDTH(26), .GAIN_WIDTH(27), .MULT_LATENCY(3))
        dutB (.clk(clk), .reset(reset), .bus(busB.slave));
    trim_seq #(.NCHAN(8), .MAG_WIDTH(26), .GAIN_WIDTH(27), .MULT_LATENCY(3))
        dutC (.clk(clk), .reset(reset), .bus(busC.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Route the selected instance's outputs to common observation signals
    always_comb begin
        curToggle  = 1'b0;
        curBusy    = 1'b0;
        curOverrun = 1'b0;
        curTrim    = '0;
        curSat     = '0;
        case (sel)
            0: begin
                curToggle = busA.trimmedToggle; curBusy = busA.busy; curOverrun = busA.overrun;
                curTrim = 256'(busA.trimmed); curSat = 16'(busA.saturated);
            end
            1: begin
                curToggle = busB.trimmedToggle; curBusy = busB.busy; curOverrun = busB.overrun;
                curTrim = 256'(busB.trimmed); curSat = 16'(busB.saturated);
            end
            default: begin
                curToggle = busC.trimmedToggle; curBusy = busC.busy; curOverrun = busC.overrun;
                curTrim = 256'(busC.trimmed); curSat = 16'(busC.saturated);
            end
        endcase
    end

    function automatic logic [255:0] packVals(input int w, input longint v[8]);
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r = r | (256'(v[k]) << (k * w));
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive operands and a one-cycle strobe; returns at the negedge after the sampling edge
    task automatic applyStimulus(input int s, input logic [255:0] mags, input logic [255:0] gns);
        @(negedge clk);
        sel = s;
        case (s)
            0: begin busA.magnitudes = mags[103:0]; busA.gains = gns[107:0]; busA.strobe = 1'b1; end
            1: begin busB.magnitudes = mags[25:0];  busB.gains = gns[26:0];  busB.strobe = 1'b1; end
            default: begin busC.magnitudes = mags[207:0]; busC.gains = gns[215:0]; busC.strobe = 1'b1; end
        endcase
        @(negedge clk);
        busA.strobe = 1'b0;
        busB.strobe = 1'b0;
        busC.strobe = 1'b0;
    endtask

    // Count edges until the result toggle flips, checking busy and output stability meanwhile
    task automatic waitResult(input string tag, input int expEdges);
        logic         oldT;
        logic [255:0] oldTrim;
        int           edges;
        logic         busyOk, stableOk;
        oldT     = curToggle;
        oldTrim  = curTrim;
        edges    = 0;
        busyOk   = 1'b1;
        stableOk = 1'b1;
        while (curToggle == oldT && edges < 60) begin
            if (!curBusy) busyOk = 1'b0;
            if (curTrim != oldTrim) stableOk = 1'b0;
            @(negedge clk);
            edges++;
        end
        checkOutput({tag, "-latency"}, 256'(edges), 256'(expEdges));
        checkOutput({tag, "-busyHeld"}, 256'(busyOk), 256'(1));
        checkOutput({tag, "-stable"}, 256'(stableOk), 256'(1));
        checkOutput({tag, "-busyDone"}, 256'(curBusy), 256'(0));
    endtask

    initial begin
        logic         tog;
        logic [255:0] mags;
        logic [255:0] gns;
        logic [255:0] unity4;
        checks = 0;
        errors = 0;
        sel    = 0;
        reset  = 1'b1;
        busA.strobe = 1'b0; busA.overrunClear = 1'b0; busA.magnitudes = '0; busA.gains = '0;
        busB.strobe = 1'b0; busB.overrunClear = 1'b0; busB.magnitudes = '0; busB.gains = '0;
        busC.strobe = 1'b0; busC.overrunClear = 1'b0; busC.magnitudes = '0; busC.gains = '0;
        unity4 = packVals(27, '{U, U, U, U, 0, 0, 0, 0});
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst-trimmed", curTrim, '0);
        checkOutput("rst-toggle", 256'(curToggle), 256'(0));
        checkOutput("rst-busy", 256'(curBusy), 256'(0));
        checkOutput("rst-overrun", 256'(curOverrun), 256'(0));
        checkOutput("rst-sat", 256'(curSat), 256'(0));

        $display("[TB] unity gain, inputs disturbed after snapshot");
        applyStimulus(0, packVals(26, '{100, 200, 300, 400, 0, 0, 0, 0}), unity4);
        busA.magnitudes = '1;
        busA.gains      = '0;
        waitResult("unity", 11);
        checkOutput("unity-trimmed", curTrim, packVals(26, '{100, 200, 300, 400, 0, 0, 0, 0}));
        checkOutput("unity-sat", 256'(curSat), 256'(0));
        checkOutput("unity-toggle", 256'(curToggle), 256'(1));

        $display("[TB] half gain rounding");
        applyStimulus(0, packVals(26, '{3, 5, 0, 1, 0, 0, 0, 0}), packVals(27, '{H, H, H, H, 0, 0, 0, 0}));
        waitResult("half", 11);
        checkOutput("half-trimmed", curTrim, packVals(26, '{2, 3, 0, 1, 0, 0, 0, 0}));

        $display("[TB] zero gain");
        applyStimulus(0, packVals(26, '{12345, MX, 1, 999, 0, 0, 0, 0}), '0);
        waitResult("zero", 11);
        checkOutput("zero-trimmed", curTrim, '0);

        $display("[TB] saturation on channel 2");
        applyStimulus(0, packVals(26, '{10, 20, MX, 40, 0, 0, 0, 0}), packVals(27, '{U, U, GMX, U, 0, 0, 0, 0}));
        waitResult("sat", 11);
        checkOutput("sat-trimmed", curTrim, packVals(26, '{10, 20, MX, 40, 0, 0, 0, 0}));
        checkOutput("sat-flags", 256'(curSat), 256'(4'b0100));

        $display("[TB] overrun from second strobe");
        applyStimulus(0, packVals(26, '{11, 22, 33, 44, 0, 0, 0, 0}), unity4);
        repeat (2) @(negedge clk);
        busA.magnitudes = 104'(packVals(26, '{55, 66, 77, 88, 0, 0, 0, 0}));
        busA.strobe = 1'b1;
        @(negedge clk);
        busA.strobe = 1'b0;
        waitResult("ovr", 8);
        checkOutput("ovr-trimmed", curTrim, packVals(26, '{11, 22, 33, 44, 0, 0, 0, 0}));
        checkOutput("ovr-sat", 256'(curSat), 256'(0));
        checkOutput("ovr-flag", 256'(curOverrun), 256'(1));
        tog = curToggle;
        repeat (20) @(negedge clk);
        checkOutput("ovr-singleToggle", 256'(curToggle), 256'(tog));
        busA.overrunClear = 1'b1;
        @(negedge clk);
        busA.overrunClear = 1'b0;
        checkOutput("ovr-cleared", 256'(curOverrun), 256'(0));

        $display("[TB] reset during request");
        applyStimulus(0, packVals(26, '{7, 8, 9, 10, 0, 0, 0, 0}), unity4);
        repeat (4) @(negedge clk);
        busA.strobe = 1'b1;
        @(negedge clk);
        busA.strobe = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("midrst-trimmed", curTrim, '0);
        checkOutput("midrst-toggle", 256'(curToggle), 256'(0));
        checkOutput("midrst-busy", 256'(curBusy), 256'(0));
        checkOutput("midrst-overrun", 256'(curOverrun), 256'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("midrst-noToggle", 256'(curToggle), 256'(0));
        applyStimulus(0, packVals(26, '{1000, 2000, 3000, 4000, 0, 0, 0, 0}), unity4);
        waitResult("postrst", 11);
        checkOutput("postrst-trimmed", curTrim, packVals(26, '{1000, 2000, 3000, 4000, 0, 0, 0, 0}));

        $display("[TB] overrun clear collisions and strobe on the update edge");
        mags = packVals(26, '{5, 6, 7, 8, 0, 0, 0, 0});
        applyStimulus(0, mags, unity4);
        for (int e = 1; e <= 11; e++) begin
            busA.strobe       = (e == 1 || e == 3 || e == 11);
            busA.overrunClear = (e == 3 || e == 5);
            if (e == 3) busA.magnitudes = '1;
            @(negedge clk);
            busA.strobe       = 1'b0;
            busA.overrunClear = 1'b0;
            if (e == 1)  checkOutput("col-setEarly", 256'(curOverrun), 256'(1));
            if (e == 3)  checkOutput("col-clearAndSet", 256'(curOverrun), 256'(1));
            if (e == 5)  checkOutput("col-clearOnly", 256'(curOverrun), 256'(0));
            if (e == 10) checkOutput("col-notYet", 256'(curToggle), 256'(1));
        end
        checkOutput("col-toggled", 256'(curToggle), 256'(0));
        checkOutput("col-updEdgeOverrun", 256'(curOverrun), 256'(1));
        checkOutput("col-busy", 256'(curBusy), 256'(0));
        checkOutput("col-trimmed", curTrim, mags);
        repeat (20) @(negedge clk);
        checkOutput("col-noRestart", 256'(curToggle), 256'(0));

        $display("[TB] single channel, 3-stage multiplier");
        applyStimulus(1, packVals(26, '{1000, 0, 0, 0, 0, 0, 0, 0}), packVals(27, '{H, 0, 0, 0, 0, 0, 0, 0}));
        waitResult("n1", 5);
        checkOutput("n1-trimmed", curTrim, 256'(500));
        checkOutput("n1-sat", 256'(curSat), 256'(0));

        $display("[TB] eight channels, 3-stage multiplier");
        gns = packVals(27, '{H, H, H, H, H, H, H, GMX});
        applyStimulus(2, packVals(26, '{1, 2, 3, 4, 5, 6, 7, MX}), gns);
        waitResult("n8", 12);
        checkOutput("n8-trimmed", curTrim, packVals(26, '{1, 1, 2, 2, 3, 3, 4, MX}));
        checkOutput("n8-sat", 256'(curSat), 256'(8'h80));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/trim_seq.md
TRIM_SEQ -- requirements
Module: trim_seq

Interface
REQ-001 SHALL have parameter NCHAN, default 4, number of channels (1..16).
REQ-002 SHALL have parameter MAG_WIDTH, default 26, unsigned magnitude width.
REQ-003 SHALL have parameter GAIN_WIDTH, default 27, unsigned gain width; unity gain = 2^(GAIN_WIDTH-1).
REQ-004 SHALL have parameter MULT_LATENCY, default 6, internal multiplier pipeline depth (>=1).
REQ-005 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port strobe  input  1  single-cycle request to trim current inputs.
REQ-008 SHALL have port magnitudes  input  NCHAN*MAG_WIDTH  channel k at bits [k*MAG_WIDTH +: MAG_WIDTH].
REQ-009 SHALL have port gains  input  NCHAN*GAIN_WIDTH  channel k at bits [k*GAIN_WIDTH +: GAIN_WIDTH].
REQ-010 SHALL have port overrunClear  input  1  clears overrun.
REQ-011 SHALL have port trimmed  output  NCHAN*MAG_WIDTH  registered trimmed magnitudes, same packing.
REQ-012 SHALL have port trimmedToggle  output  1  inverts once per completed result set.
REQ-013 SHALL have port saturated  output  NCHAN  per-channel saturation flag of current result set.
REQ-014 SHALL have port busy  output  1  high while a request is in progress.
REQ-015 SHALL have port overrun  output  1  sticky: strobe arrived while busy.

Function
REQ-016 SHALL use one shared multiplier, time-multiplexed across channels, MULT_LATENCY registered stages, no vendor core.
REQ-017 SHALL have states IDLE, ISSUE, DRAIN, UPDATE.
REQ-018 IDLE: strobe high at an edge SHALL snapshot magnitudes and gains, set busy, go ISSUE.
REQ-019 ISSUE SHALL present channel 0..NCHAN-1 to multiplier, one per cycle, ascending; after channel NCHAN-1 go DRAIN.
REQ-020 DRAIN SHALL wait until last product leaves pipeline, then go UPDATE.
REQ-021 UPDATE SHALL, in one edge, load all trimmed and saturated bits, invert trimmedToggle, clear busy, go IDLE.
REQ-022 Latency: trimmed/trimmedToggle SHALL change exactly NCHAN+MULT_LATENCY+1 edges after the edge sampling strobe; busy high for all intermediate cycles.
REQ-023 trimmed SHALL stay stable between updates; no partial results visible.
REQ-024 Per channel: P = mag*gain (MAG_WIDTH+GAIN_WIDTH bits); R = P[GAIN_WIDTH-1 +: MAG_WIDTH+1] + P[GAIN_WIDTH-2] (round half up).
REQ-025 If R >= 2^MAG_WIDTH, result SHALL be 2^MAG_WIDTH-1 and saturated[k]=1; else result = R, saturated[k]=0.
REQ-026 Strobe while busy (any state other than IDLE, including the UPDATE edge) SHALL be ignored, set overrun, not disturb in-flight request.
REQ-027 overrunClear SHALL clear overrun; simultaneous overrunClear and new overrun event SHALL leave overrun=1.
REQ-028 Input changes after the snapshot edge SHALL not affect the in-flight result.

Reset
REQ-029 reset SHALL immediately force state IDLE, trimmed=0, saturated=0, trimmedToggle=0, busy=0, overrun=0, and discard in-flight products.
REQ-030 After reset release, the first strobe SHALL be handled per REQ-018 with no residual pipeline data.

Verification (NCHAN=4, MAG_WIDTH=26, GAIN_WIDTH=27, MULT_LATENCY=6)
REQ-031 Unity: gains all 67108864, mags 100/200/300/400, strobe -> trimmed 100/200/300/400, toggle 0->1 at edge 11, busy high 10 cycles, saturated=0.
REQ-032 Rounding: gain 33554432 (0.5), mags 3/5/0/1 -> 2/3/0/1; gain 0 any mag -> 0.
REQ-033 Saturation: mag 67108863, gain 134217727 on ch2 -> trimmed ch2 = 67108863, saturated=4'b0100, other channels unaffected.
REQ-034 Overrun: second strobe 3 cycles after first -> single toggle, first-request results, overrun=1; overrunClear pulse -> overrun=0.
REQ-035 Reset: assert reset 5 cycles after strobe -> all outputs 0 immediately, no toggle later; next strobe completes in 11 edges.
REQ-036 Parameter sweep: NCHAN=1 and NCHAN=8 with MULT_LATENCY=3 -> latency 5 and 12 edges, results per REQ-024/025.
